prio_arbiter: RTL and testbench
===============================

Name: prio_arbiter

Overview:
- Parametrised, registered successor to the 8-to-3 combinational priority encoder.
- Arbitrates N request lines and produces a registered one-hot grant, a binary grant index and an idle flag.
- Fixed-priority mode: highest index wins, the same ordering as the encoder.
- Round-robin mode: the search start rotates for fairness.
- Grant lock with a bounded hold counter.
- Used wherever several requesters share one resource port.

Parameters:
- N, 8, number of requesters (2..64).
- IDX_W, $clog2(N), width of grant_idx (derived; do not override).
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold a grant while others wait (1..255).
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- rr_mode  input  1  0 = fixed priority (highest index wins), 1 = round robin.
- grant  output  N  registered one-hot grant; all-zero when nothing granted.
- grant_idx  output  IDX_W  binary index of the granted requester; 0 when grant_valid=0.
- grant_valid  output  1  high when grant is non-zero.
- idle  output  1  high when grant_valid=0; registered, equals ~grant_valid.
- hold_cnt  output  HOLD_W  cycles the current grant has been held; 0 when idle.

Behaviour:
- Reset (async, while rst=1):
  - grant=0, grant_idx=0, grant_valid=0, idle=1, hold_cnt=0.
  - Internal round-robin pointer ptr=N-1.
  - Takes effect immediately, including mid-grant; first grant can appear on the first rising edge after rst falls.
- Latency: a request seen at edge k produces its grant at edge k+1 (one register stage). No combinational path from req to outputs.
- Each cycle, the next state is chosen by the first of these that applies:
  - HOLD: grant_valid=1, req[grant_idx]=1, and (hold_cnt < MAX_HOLD-1 or no other req bit set) -> grant unchanged; hold_cnt increments, saturating at 2^HOLD_W-1.
  - PREEMPT: grant_valid=1, req[grant_idx]=1, hold_cnt = MAX_HOLD-1, and another req bit set -> arbitrate among req with the current holder masked out; new grant next edge, hold_cnt=0.
  - REARB: the current holder has dropped req, or grant_valid=0 -> arbitrate among the full req vector.
    - Any bit set: new grant next edge (no bubble cycle), hold_cnt=0.
    - No bit set: grant=0, grant_valid=0, idle=1, hold_cnt=0.
- Arbitration rule, fixed priority (rr_mode=0): the highest set index wins. Example: req=8'b0101_0010 -> index 6.
- Arbitration rule, round robin (rr_mode=1):
  - Search descends from ptr, wrapping from 0 to N-1.
  - First set bit wins.
  - On every new grant to index w, ptr <= (w==0) ? N-1 : w-1.
- ptr updates only on new grants in round-robin mode, and is held otherwise.
- A new grant to the same index as the previous one (drop then re-request) still counts as a new grant: hold_cnt restarts at 0.
- rr_mode changes take effect at the next arbitration; they never break a current hold.
- grant is always one-hot or zero. grant_idx is consistent with grant in the same cycle.
- Single requester: never preempted (no other req set), so hold_cnt saturates.
- req bits for non-granted requesters may toggle freely. Only arbitration edges sample them.

Test Plan:
- Reset and idle: assert rst mid-grant (grant=8'h40) -> outputs immediately grant=0, idle=1, hold_cnt=0. Release rst with req=0 -> idle stays 1.
- Fixed priority: rr_mode=0, req=8'b0001_0110 -> next edge grant=8'h10, grant_idx=4. Drop req[4] -> next edge grant_idx=2, no idle cycle in between.
- Round-robin fairness: rr_mode=1, req=8'hFF held; each requester drops its bit for one cycle after its grant. Required grant order is 7,6,5,...,0,7, with ptr wrapping correctly.
- Hold limit: MAX_HOLD=4, req=8'b1000_0001 constant, fixed mode.
  - Grant 7 is held for 4 cycles (hold_cnt 0..3), then grant 0.
  - Grant 0 is held for 4 cycles, then grant 7.
- Saturation with single requester: req=8'h08 for 300 cycles -> grant_idx=3 throughout; hold_cnt saturates at 255 without preemption.
- Mode switch mid-hold: holder index 5, toggle rr_mode -> grant unchanged until the holder drops. The next arbitration uses the new mode.

Source files
------------

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection with a
// bounded grant hold, one-hot plus binary grant outputs and an idle flag.
module prio_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic              rr_mode,
  output logic [N-1:0]      grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic              idle,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic [N-1:0]      ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0]  ptr;
  logic [N-1:0]      grant_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic              vld_nx;
  logic [HOLD_W-1:0] hold_nx;
  logic [IDX_W-1:0]  ptr_nx;
  logic [N-1:0]      cand;
  logic [IDX_W-1:0]  win;
  logic              holding;
  logic              others;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_SAT) ? v : v + 1'b1;
  endfunction

  // Highest set index wins; later (higher) hits overwrite earlier ones.
  function automatic logic [IDX_W-1:0] pick_fixed(input logic [N-1:0] m);
    logic [IDX_W-1:0] w;
    logic [N-1:0]     s;
    w = '0;
    for (int i = 0; i < N; i++) begin
      s = m >> i;
      if (s[0]) w = IDX_W'(i);
    end
    return w;
  endfunction

  // Descending search from start with wrap; iterate farthest-first so the
  // nearest hit to start is the last one written.
  function automatic logic [IDX_W-1:0] pick_rr(input logic [N-1:0] m,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] w;
    logic [N-1:0]     s;
    int               j;
    w = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) - k;
      if (j < 0) j = j + N;
      s = m >> j;
      if (s[0]) w = IDX_W'(j);
    end
    return w;
  endfunction

  always_comb begin
    grant_nx = grant;
    idx_nx   = grant_idx;
    vld_nx   = grant_valid;
    hold_nx  = hold_cnt;
    ptr_nx   = ptr;
    cand     = req;
    win      = '0;
    holding  = grant_valid & req[grant_idx];
    others   = |(req & ~grant);

    if (holding && (hold_cnt < HOLD_LIM || !others)) begin
      hold_nx = sat_inc(hold_cnt);
    end else begin
      // Preemption excludes the current holder from the contest.
      if (holding) cand = req & ~grant;
      if (|cand) begin
        win      = rr_mode ? pick_rr(cand, ptr) : pick_fixed(cand);
        grant_nx = ONE_HOT0 << win;
        idx_nx   = win;
        vld_nx   = 1'b1;
        hold_nx  = '0;
        if (rr_mode) ptr_nx = (win == '0) ? LAST_IDX : win - 1'b1;
      end else begin
        grant_nx = '0;
        idx_nx   = '0;
        vld_nx   = 1'b0;
        hold_nx  = '0;
      end
    end
  end

  // Single register stage: all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      idle        <= 1'b1;
      hold_cnt    <= '0;
      ptr         <= LAST_IDX;
    end else begin
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= vld_nx;
      idle        <= ~vld_nx;
      hold_cnt    <= hold_nx;
      ptr         <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed-vector bench for prio_arbiter (N=8, MAX_HOLD=4, HOLD_W=8).
module tb_prio_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         rr_mode;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         grant_valid;
  logic         idle;
  logic [7:0]   hold_cnt;

  int n_vec = 0;
  int n_err = 0;
  int prev;
  int exp_i;

  prio_arbiter #(.N(N), .MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
    .idle(idle), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".grant"}, 64'(grant), 64'h0);
    chk({tag, ".idx"}, 64'(grant_idx), 64'h0);
    chk({tag, ".valid"}, 64'(grant_valid), 64'h0);
    chk({tag, ".idle"}, 64'(idle), 64'h1);
    chk({tag, ".hold"}, 64'(hold_cnt), 64'h0);
  endtask

  task automatic expect_grant(input string tag, input int idx, input int hold);
    logic [N-1:0] g;
    g = 8'h01 << idx;
    chk({tag, ".grant"}, 64'(grant), 64'(g));
    chk({tag, ".idx"}, 64'(grant_idx), 64'(idx));
    chk({tag, ".valid"}, 64'(grant_valid), 64'h1);
    chk({tag, ".idle"}, 64'(idle), 64'h0);
    chk({tag, ".hold"}, 64'(hold_cnt), 64'(hold));
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rr_mode = 1'b0;
    tick();
    tick();
    expect_idle("reset");

    // Async reset mid-grant
    rst = 1'b0;
    req = 8'h40;
    tick();
    expect_grant("pre_rst", 6, 0);
    tick();
    expect_grant("pre_rst_hold", 6, 1);
    rst = 1'b1;
    #1;
    expect_idle("async_rst");
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    expect_idle("post_rst");

    // Fixed priority, then re-arbitration without a bubble
    rr_mode = 1'b0;
    req = 8'b0001_0110;
    tick();
    expect_grant("fixed", 4, 0);
    req = 8'b0000_0110;
    tick();
    expect_grant("fixed_drop", 2, 0);
    req = '0;
    tick();
    expect_idle("fixed_idle");

    // Round-robin fairness: 7,6,...,0,7
    rr_mode = 1'b1;
    req = 8'hFF;
    tick();
    expect_grant("rr0", 7, 0);
    prev = 7;
    for (int k = 1; k <= 8; k++) begin
      req = 8'hFF & ~(8'h01 << prev);
      tick();
      exp_i = (15 - k) % 8;
      expect_grant($sformatf("rr%0d", k), exp_i, 0);
      prev = exp_i;
    end
    req = '0;
    tick();
    expect_idle("rr_idle");

    // Hold limit with two contenders in fixed mode
    rr_mode = 1'b0;
    req = 8'b1000_0001;
    for (int c = 0; c < 9; c++) begin
      tick();
      expect_grant($sformatf("hold%0d", c), ((c / 4) % 2 == 0) ? 7 : 0, c % 4);
    end
    req = '0;
    tick();
    expect_idle("hold_idle");

    // Single requester: hold counter saturates, never preempted
    req = 8'h08;
    for (int c = 0; c < 300; c++) begin
      tick();
      expect_grant($sformatf("sat%0d", c), 3, (c > 255) ? 255 : c);
    end
    req = '0;
    tick();
    expect_idle("sat_idle");

    // Mode toggles during a hold leave the grant alone
    rr_mode = 1'b0;
    req = 8'h20;
    tick();
    expect_grant("mode0", 5, 0);
    rr_mode = 1'b1;
    tick();
    expect_grant("mode1", 5, 1);
    rr_mode = 1'b0;
    tick();
    expect_grant("mode2", 5, 2);
    rr_mode = 1'b1;
    tick();
    expect_grant("mode3", 5, 3);
    tick();
    expect_grant("mode4", 5, 4);
    // Holder drops; rr search from ptr=6 picks 0 rather than fixed-mode 7
    req = 8'h81;
    tick();
    expect_grant("mode_rearb", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
